// File: rtl/eth_wb_mem_arbiter_if.sv
// rtl/eth_wb_mem_arbiter_if.sv - Wishbone bus bundle used by the memory arbiter
// Purpose: one Wishbone B4 link (request + response) between a master and a slave.
// Signals: cyc/stb/we/adr/dat_w/sel/cti/bte travel master->slave,
//          dat_r/ack/err travel slave->master.
// Modports: master (drives the request), slave (drives the response).
interface eth_wb_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/eth_wb_mem_arbiter.sv
// rtl/eth_wb_mem_arbiter.sv - two-master round-robin Wishbone arbiter with ack timeout
// Purpose: shares one memory slave between the MAC DMA master (m0) and the
//          host loader (m1). Grant is held for a whole cyc, and a stalled
//          access is terminated with err after TIMEOUT cycles.
// Ports: wb_clk_i / wb_rst_i  clock, synchronous active-high reset
//        m0, m1               master-facing buses (slave modport)
//        s                    memory-facing bus (master modport)
//        gnt_o                one-hot grant, 00 when idle
//        timeout_o            one-cycle pulse when an access times out
module eth_wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  eth_wb_mem_arbiter_if.slave   m0,
  eth_wb_mem_arbiter_if.slave   m1,
  eth_wb_mem_arbiter_if.master  s,
  output logic [1:0]            gnt_o,
  output logic                  timeout_o
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            g_cyc, g_stb, g_we;
  logic [AW-1:0]   g_adr;
  logic [DW-1:0]   g_dat;
  logic [DW/8-1:0] g_sel;
  logic [2:0]      g_cti;
  logic [1:0]      g_bte;
  logic            stb_out;
  logic            to_hit;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Exits always pass through IDLE, so there is never a back-to-back handoff.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_gnt_q)) begin
          state_d    = OWN0;
          last_gnt_d = 1'b0;
        end else if (m1.cyc) begin
          state_d    = OWN1;
          last_gnt_d = 1'b1;
        end
      end
      OWN0:    if (!m0.cyc) state_d = IDLE;
      OWN1:    if (!m1.cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    case (state_q)
      OWN0: begin
        g_cyc = m0.cyc;
        g_stb = m0.stb;
        g_we  = m0.we;
        g_adr = m0.adr;
        g_dat = m0.dat_w;
        g_sel = m0.sel;
        g_cti = m0.cti;
        g_bte = m0.bte;
      end
      OWN1: begin
        g_cyc = m1.cyc;
        g_stb = m1.stb;
        g_we  = m1.we;
        g_adr = m1.adr;
        g_dat = m1.dat_w;
        g_sel = m1.sel;
        g_cti = m1.cti;
        g_bte = m1.bte;
      end
      default: ;
    endcase
  end

  // Timeout fires combinationally on the TIMEOUT-th stalled cycle; the strobe
  // is withdrawn in that same cycle so the slave never sees a late access.
  assign to_hit  = (cnt_q == CW'(TIMEOUT - 1)) && g_stb && !s.ack && !s.err;
  assign stb_out = g_stb && !to_hit;

  always_comb begin
    cnt_d = '0;
    if (stb_out && !s.ack && !s.err && (state_d == state_q))
      cnt_d = cnt_q + CW'(1);
  end

  assign s.cyc   = g_cyc;
  assign s.stb   = stb_out;
  assign s.we    = g_we;
  assign s.adr   = g_adr;
  assign s.dat_w = g_dat;
  assign s.sel   = g_sel;
  assign s.cti   = g_cti;
  assign s.bte   = g_bte;

  assign m0.ack   = (state_q == OWN0) && s.ack;
  assign m0.err   = (state_q == OWN0) && (s.err || to_hit);
  assign m0.dat_r = s.dat_r;
  assign m1.ack   = (state_q == OWN1) && s.ack;
  assign m1.err   = (state_q == OWN1) && (s.err || to_hit);
  assign m1.dat_r = s.dat_r;

  assign gnt_o     = {state_q == OWN1, state_q == OWN0};
  assign timeout_o = to_hit;
endmodule

// File: doc/eth_wb_mem_arbiter.md
Name: eth_wb_mem_arbiter

Overview:
- Two-master Wishbone arbiter in front of the single testbench memory slave that serves the Ethernet MAC's DMA master port.
- Master 0 is the MAC DMA master. Master 1 is the host/bench loader, which preloads buffer descriptors and data and reads back received frames.
- Round-robin arbitration with grant locked for a whole bus cycle (cyc high), including bursts.
- Per-access ack timeout that returns an error to the master instead of hanging the bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT, 256, cycles with slave stb asserted and no ack/err before a timeout error is returned; must be >=2.

Ports:
- wb_clk_i  in  1  Wishbone clock; sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  master N (N=0,1) request.
- mN_adr_i  in  AW  master N address.
- mN_dat_i  in  DW  master N write data.
- mN_sel_i  in  DW/8  master N byte select.
- mN_cti_i  in  3  master N cycle type identifier.
- mN_bte_i  in  2  master N burst type extension.
- mN_dat_o  out  DW  read data to master N.
- mN_ack_o, mN_err_o  out  1 each  master N ack/err.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to memory slave.
- s_adr_o  out  AW  to memory slave.
- s_dat_o  out  DW  to memory slave.
- s_sel_o  out  DW/8  to memory slave.
- s_cti_o  out  3  to memory slave.
- s_bte_o  out  2  to memory slave.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i  in  1 each  slave ack/err.
- gnt_o  out  2  one-hot current grant; 00 = idle.
- timeout_o  out  1  one-cycle pulse on timeout.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registered state plus last_gnt pointer.
- Reset (sync): state IDLE, last_gnt=1 so m0 wins first, timeout counter 0. Resulting outputs: gnt_o=00, timeout_o=0, all s_* control outputs 0, all mN_ack/err 0.
- IDLE transitions:
  - Only m0_cyc -> OWN0; only m1_cyc -> OWN1.
  - Both -> the master that is not last_gnt.
  - Neither -> stay IDLE.
  - Grant takes effect next edge (1-cycle arbitration latency); last_gnt updated on entry.
- OWNn: remain while mN_cyc_i=1. Bursts (cti 001/010, end 111) are never split. The other master's cyc is ignored.
- OWNn exit: mN_cyc_i=0 -> IDLE next edge. IDLE always lasts at least one cycle between grants, so no back-to-back handoff.
- Request mux (combinational from state): s_adr/dat/sel/we/cti/bte = granted master's inputs. s_cyc_o = granted cyc. s_stb_o = granted stb & ~to_hit. In IDLE, s_cyc/s_stb=0 and the other s_* outputs are 0.
- Response routing: mN_ack_o = (state==OWNn) & s_ack_i. mN_err_o = (state==OWNn) & (s_err_i | to_hit). mN_dat_o = s_dat_i for both (data valid only with ack). The non-granted master never sees ack/err.
- Timeout counter:
  - Increments each cycle s_stb_o=1 with s_ack_i=0 and s_err_i=0.
  - Clears on ack, err, to_hit, state change, or stb low.
  - to_hit = (count==TIMEOUT-1) & granted stb & ~s_ack_i & ~s_err_i. It is combinational, so err arrives on the TIMEOUT-th stalled cycle.
  - On to_hit: s_stb_o forced 0 that cycle; mN_err_o=1; timeout_o=1; counter clears. Grant is retained until the master drops cyc.
- Simultaneous s_ack_i and to_hit cannot occur (to_hit requires ~s_ack_i). s_ack_i and s_err_i together: both pass through, and the master treats it as an error.
- Reset mid-transfer: the next edge forces IDLE, and all s_* control and mN_ack/err outputs go 0 that cycle. No pending response is replayed.
- gnt_o: OWN0=01, OWN1=10, IDLE=00.

Test Plan:
- Reset, then m0 single write: adr 0x100, dat 0xDEADBEEF, sel F; slave acks 2 cycles after stb. Required: s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o coincident with s_ack_i; gnt_o=01; m1_ack_o stays 0.
- m0 and m1 raise cyc in the same cycle right after reset. Required: m0 granted first; after m0 drops cyc, exactly 1 IDLE cycle (gnt_o=00), then gnt_o=10; m1 read of 0x200 returns the slave's 0x12345678 on m1_dat_o with m1_ack_o.
- Both masters continuously request 4 single accesses each. Required: grant sequence 01,10,01,10,... with no master granted twice in a row.
- m0 4-beat incrementing burst (cti 010,010,010,111), m1 cyc asserted during beat 2. Required: s_cti_o follows m0 unbroken; gnt_o=01 until m0_cyc_i falls; m1 granted 2 cycles after that.
- TIMEOUT=16, slave never acks m0 stb. Required: m0_err_o and timeout_o pulse on the 16th stalled cycle with s_stb_o=0 that cycle; after m0 drops cyc, a pending m1 is granted normally.
- wb_rst_i asserted during m1's burst beat 3. Required: next edge gnt_o=00, s_cyc_o=0, no m1_ack_o. After release, a fresh m0/m1 contention grants m0 first.
